btn_conditioner: RTL and testbench

Conditions the four raw player push-buttons into rate-limited movement strobes for the paddle-position controller. Each input is synchronised, debounced, and turned into a one-cycle strobe on press, then repeated at a fixed rate while the button is held. Its outputs connect directly to the `ply1_up`/`ply1_down`/`ply2_up`/`ply2_down` inputs of the paddle controller, which then moves one `speed` step per strobe rather than one step per clock.

---
 rtl/btn_conditioner.sv | 117 +++++++++++
 tb/tb_btn_conditioner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: sync, debounce, press strobe plus auto-repeat per button.
// Build option: define BTNCOND_ACTIVE_LOW_EN for active-low button pins.

module btn_lane #(
    parameter int DEB_CYCLES = 250000,
    parameter int RATE_DIV   = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    input  logic conflict,
    output logic state,
    output logic stb
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int RW = $clog2(RATE_DIV);

    logic [1:0]    sync;
    logic [DW-1:0] deb_cnt, deb_cnt_nxt;
    logic [RW-1:0] rep_cnt;
    logic          state_nxt;
    logic          state_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= '0;
        else       sync <= {sync[0], raw};
    end

    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = '0;
        if (sync[1] != state) begin
            if (deb_cnt == DW'(DEB_CYCLES - 1)) state_nxt = sync[1];
            else                                deb_cnt_nxt = deb_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_cnt <= '0;
            state   <= 1'b0;
            state_d <= 1'b0;
        end else begin
            deb_cnt <= deb_cnt_nxt;
            state   <= state_nxt;
            state_d <= state;
        end
    end

    // A release being accepted this edge also kills the strobe, so none lands with the fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt <= '0;
            stb     <= 1'b0;
        end else if (!state || !state_nxt || conflict) begin
            rep_cnt <= '0;
            stb     <= 1'b0;
        end else if (!state_d) begin
            rep_cnt <= '0;
            stb     <= 1'b1;
        end else if (rep_cnt == RW'(RATE_DIV - 1)) begin
            rep_cnt <= '0;
            stb     <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
            stb     <= 1'b0;
        end
    end
endmodule

module btn_conditioner #(
    parameter int DEB_CYCLES = 250000,
    parameter int RATE_DIV   = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_state,
    output logic       ply1_up,
    output logic       ply1_down,
    output logic       ply2_up,
    output logic       ply2_down
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] raw_in;
    logic [NUM_LANES-1:0] conflict;
    logic [NUM_LANES-1:0] stb;

`ifdef BTNCOND_ACTIVE_LOW_EN
    assign raw_in = ~btn_raw;
`else
    assign raw_in = btn_raw;
`endif

    // Up and down of one player held together cancel each other.
    assign conflict = {{2{&btn_state[3:2]}}, {2{&btn_state[1:0]}}};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        btn_lane #(
            .DEB_CYCLES(DEB_CYCLES),
            .RATE_DIV  (RATE_DIV)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .raw     (raw_in[i]),
            .conflict(conflict[i]),
            .state   (btn_state[i]),
            .stb     (stb[i])
        );
    end

    assign ply1_up   = stb[0];
    assign ply1_down = stb[1];
    assign ply2_up   = stb[2];
    assign ply2_down = stb[3];
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB_CYCLES=4, RATE_DIV=8.
// Observed vector per cycle is {ply2_down, ply2_up, ply1_down, ply1_up, btn_state}.

module tb_btn_conditioner;
    logic       clk;
    logic       rstn;
    logic [3:0] btn_raw;
    logic [3:0] btn_state;
    logic       ply1_up, ply1_down, ply2_up, ply2_down;

    int n_chk  = 0;
    int n_pass = 0;

    btn_conditioner #(.DEB_CYCLES(4), .RATE_DIV(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_raw  (btn_raw),
        .btn_state(btn_state),
        .ply1_up  (ply1_up),
        .ply1_down(ply1_down),
        .ply2_up  (ply2_up),
        .ply2_down(ply2_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {ply2_down, ply2_up, ply1_down, ply1_up, btn_state};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mask is the set of pressed buttons; pin polarity follows the build
    task automatic drive(input logic [3:0] mask);
`ifdef BTNCOND_ACTIVE_LOW_EN
        btn_raw = ~mask;
`else
        btn_raw = mask;
`endif
    endtask

    task automatic reset_idle();
        rstn = 1'b0;
        drive(4'h0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Press mask at cycle 0, release at rel_at: state high over cycles [6, rel_at+6),
    // strobes at 7, 15, 23, ... while state is still high.
    task automatic run_press(input string tag, input logic [3:0] mask, input int rel_at, input int ncyc);
        logic [3:0] es, ep;
        drive(mask);
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            es = (c >= 6 && c < rel_at + 6) ? mask : 4'h0;
            ep = (c >= 7 && c < rel_at + 6 && ((c - 7) % 8) == 0) ? mask : 4'h0;
            chk($sformatf("%s c%0d", tag, c), obs(), {ep, es});
            if (c == rel_at) drive(4'h0);
        end
    endtask

    initial begin
        logic [3:0] es, ep;
        rstn = 1'b0;
        drive(4'hF);

        // reset held with every button pressed
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("reset c%0d", c), obs(), 8'h00);
        end

        // clean press and release on ply1 up
        reset_idle();
        run_press("press", 4'b0001, 24, 40);

        // ply1 down and ply2 up together, no conflict between players
        reset_idle();
        run_press("cross", 4'b0110, 16, 26);

        // bounce on ply2 up: 3 high, 3 low, repeated
        reset_idle();
        for (int c = 1; c <= 38; c++) begin
            drive((c <= 30 && ((c - 1) / 3) % 2 == 0) ? 4'b0100 : 4'b0000);
            tick();
            chk($sformatf("bounce c%0d", c), obs(), 8'h00);
        end

        // conflict on player 1, then release down at cycle 20
        reset_idle();
        drive(4'b0011);
        for (int c = 1; c <= 52; c++) begin
            tick();
            es = (c < 6) ? 4'b0000 : (c < 26) ? 4'b0011 : 4'b0001;
            ep = (c == 34 || c == 42 || c == 50) ? 4'b0001 : 4'b0000;
            chk($sformatf("conflict c%0d", c), obs(), {ep, es});
            if (c == 20) drive(4'b0001);
        end

        // independent players, then async reset mid-cycle
        reset_idle();
        drive(4'b1001);
        for (int c = 1; c <= 18; c++) begin
            tick();
            es = (c >= 6) ? 4'b1001 : 4'b0000;
            ep = (c == 7 || c == 15) ? 4'b1001 : 4'b0000;
            chk($sformatf("indep c%0d", c), obs(), {ep, es});
        end
        #3;
        rstn = 1'b0;
        #1;
        chk("async_rst", obs(), 8'h00);
        tick();
        tick();
        chk("rst_held", obs(), 8'h00);

        // buttons held through reset release count as a fresh press
        rstn = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            es = (c >= 6) ? 4'b1001 : 4'b0000;
            ep = (c == 7 || c == 15) ? 4'b1001 : 4'b0000;
            chk($sformatf("post_rst c%0d", c), obs(), {ep, es});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
